// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: operand, command and HI/LO result bundle for the multiply/divide unit.
interface mult_div_unit_if;
  logic [31:0] BusA;
  logic [31:0] BusB;
  logic        Start;
  logic [1:0]  Op;
  logic        HiWr;
  logic        LoWr;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;
  modport master (
    output BusA, BusB, Start, Op, HiWr, LoWr,
    input  Busy, Done, DivZero, Hi, Lo
  );
  modport slave (
    input  BusA, BusB, Start, Op, HiWr, LoWr,
    output Busy, Done, DivZero, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU with HI/LO registers, 33-cycle latency.
module mult_div_unit (
  input  logic            Clk,
  input  logic            Reset,
  mult_div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic        sa_q, sa_d, sb_q, sb_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d, dz_q, dz_d;
  logic        busy, start_go, mt_go, fix;
  logic [31:0] a_abs, b_abs;
  logic [32:0] sum, shifted, diff;
  logic        ge;
  logic [63:0] mul_acc, div_acc, prod;
  logic [31:0] quot, remv, a_org, hi_fix, lo_fix;
  logic        neg, dz;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (bus.Start ? RUN : IDLE) :
              state_q == RUN  ? (cnt_q == 5'd31 ? FIX : RUN) : IDLE;
    cnt_d   = state_q == RUN ? cnt_q + 5'd1 : 5'd0;
  end
  always_comb begin
    busy     = state_q != IDLE;
    start_go = state_q == IDLE && bus.Start;
    mt_go    = state_q == IDLE && !bus.Start;
    fix      = state_q == FIX;
  end
  // Multiply keeps the multiplier in acc[31:0]; divide keeps dividend/quotient there.
  always_comb begin
    a_abs   = (bus.Op[0] && bus.BusA[31]) ? -bus.BusA : bus.BusA;
    b_abs   = (bus.Op[0] && bus.BusB[31]) ? -bus.BusB : bus.BusB;
    sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    mul_acc = {sum, acc_q[31:1]};
    shifted = {rem_q, acc_q[31]};
    diff    = shifted - {1'b0, b_q};
    ge      = !diff[32];
    div_acc = {acc_q[63:32], acc_q[30:0], ge};
    neg     = sa_q ^ sb_q;
    prod    = neg ? -acc_q : acc_q;
    quot    = neg ? -acc_q[31:0] : acc_q[31:0];
    remv    = sa_q ? -rem_q : rem_q;
    a_org   = sa_q ? -a_q : a_q;
    dz      = op_q[1] && b_q == 32'd0;
    hi_fix  = dz ? a_org : op_q[1] ? remv : prod[63:32];
    lo_fix  = dz ? 32'hFFFF_FFFF : op_q[1] ? quot : prod[31:0];
  end
  always_comb begin
    op_d   = start_go ? bus.Op : op_q;
    sa_d   = start_go ? bus.Op[0] & bus.BusA[31] : sa_q;
    sb_d   = start_go ? bus.Op[0] & bus.BusB[31] : sb_q;
    a_d    = start_go ? a_abs : a_q;
    b_d    = start_go ? b_abs : b_q;
    acc_d  = start_go ? {32'd0, bus.Op[1] ? a_abs : b_abs} :
             state_q == RUN ? (op_q[1] ? div_acc : mul_acc) : acc_q;
    rem_d  = start_go ? 32'd0 :
             state_q == RUN && op_q[1] ? (ge ? diff[31:0] : shifted[31:0]) : rem_q;
    hi_d   = fix ? hi_fix : (mt_go && bus.HiWr) ? bus.BusA : hi_q;
    lo_d   = fix ? lo_fix : (mt_go && bus.LoWr) ? bus.BusA : lo_q;
    done_d = fix;
    dz_d   = fix && dz;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op_q   <= 2'd0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      acc_q  <= 64'd0;
      rem_q  <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      rem_q  <= rem_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end
  assign bus.Busy    = busy;
  assign bus.Done    = done_q;
  assign bus.DivZero = dz_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
endmodule
